// File: rtl/interp_pkg.sv
// Shared constants for the bilinear interpolator: weight format, RGB565 field map
// and the saturating index increment used by the column/row counters.
package interp_pkg;

    localparam int FRAC_W     = 11;
    localparam int PIX_W      = 16;
    localparam int LAT        = 4;
    localparam int WEIGHT_ONE = 2048;
    localparam int ROUND_BIAS = 1 << 21;

    localparam int R_LSB = 11;
    localparam int R_W   = 5;
    localparam int G_LSB = 5;
    localparam int G_W   = 6;
    localparam int B_LSB = 0;
    localparam int B_W   = 5;

    localparam int IDX_W = 11;
    typedef logic [IDX_W-1:0] idx_t;

    function automatic idx_t sat_inc(input idx_t v);
        return (&v) ? v : v + IDX_W'(1);
    endfunction

endpackage

// File: rtl/bilinear_interp_if.sv
// Pixel stream bundle: sync/weight/neighbour inputs and the interpolated output.
interface bilinear_interp_if #(
    parameter int FRAC_W = interp_pkg::FRAC_W,
    parameter int PIX_W  = interp_pkg::PIX_W
);
    import interp_pkg::*;

    logic              i_fsyn;
    logic              i_hsyn;
    logic [FRAC_W-1:0] iv_fx;
    logic [FRAC_W-1:0] iv_fy;
    logic [PIX_W-1:0]  iv_b11;
    logic [PIX_W-1:0]  iv_b12;
    logic [PIX_W-1:0]  iv_b21;
    logic [PIX_W-1:0]  iv_b22;
    logic              o_fsyn;
    logic              o_hsyn;
    logic [PIX_W-1:0]  ov_pix;
    idx_t              ov_col;
    idx_t              ov_row;

    modport master (
        output i_fsyn, i_hsyn, iv_fx, iv_fy, iv_b11, iv_b12, iv_b21, iv_b22,
        input  o_fsyn, o_hsyn, ov_pix, ov_col, ov_row
    );

    modport slave (
        input  i_fsyn, i_hsyn, iv_fx, iv_fy, iv_b11, iv_b12, iv_b21, iv_b22,
        output o_fsyn, o_hsyn, ov_pix, ov_col, ov_row
    );

endinterface

// File: rtl/lerp_ch.sv
// One colour channel of the interpolator: horizontal lerp (S2), vertical lerp (S3),
// round/clamp into the output register (S4, loaded only for valid pixels).
module lerp_ch #(
    parameter int CW     = 5,
    parameter int FRAC_W = interp_pkg::FRAC_W
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    input  logic              en,
    input  logic [CW-1:0]     b11,
    input  logic [CW-1:0]     b12,
    input  logic [CW-1:0]     b21,
    input  logic [CW-1:0]     b22,
    input  logic [FRAC_W:0]   wx,
    input  logic [FRAC_W:0]   wy,
    input  logic [FRAC_W-1:0] fx,
    input  logic [FRAC_W-1:0] fy,
    output logic [CW-1:0]     res
);
    import interp_pkg::*;

    localparam int TW = CW + FRAC_W + 1;
    localparam int SW = TW + FRAC_W + 1;
    localparam int SH = 2 * FRAC_W;

    logic [TW-1:0]     top_q;
    logic [TW-1:0]     bot_q;
    logic [FRAC_W:0]   wy_q;
    logic [FRAC_W-1:0] fy_q;
    logic [SW-1:0]     sum_q;
    logic [SW:0]       rnd;
    logic [SW:0]       quo;
    logic [CW-1:0]     res_n;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            top_q <= '0;
            bot_q <= '0;
            wy_q  <= '0;
            fy_q  <= '0;
            sum_q <= '0;
        end else begin
            top_q <= TW'(b11) * TW'(wx) + TW'(b12) * TW'(fx);
            bot_q <= TW'(b21) * TW'(wx) + TW'(b22) * TW'(fx);
            wy_q  <= wy;
            fy_q  <= fy;
            sum_q <= SW'(top_q) * SW'(wy_q) + SW'(bot_q) * SW'(fy_q);
        end
    end

    always_comb begin
        rnd   = {1'b0, sum_q} + (SW+1)'(ROUND_BIAS);
        quo   = rnd >> SH;
        res_n = (quo > (SW+1)'((1 << CW) - 1)) ? '1 : quo[CW-1:0];
    end

    // Output register holds the last valid pixel between lines.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n)
            res <= '0;
        else if (en)
            res <= res_n;
    end

endmodule

// File: rtl/bilinear_interp.sv
// RGB565 bilinear interpolator: input register stage, three channel lerps,
// sync delay line and output column/row counters.
module bilinear_interp #(
    parameter int FRAC_W = interp_pkg::FRAC_W,
    parameter int PIX_W  = interp_pkg::PIX_W,
    parameter int LAT    = interp_pkg::LAT
) (
    input  logic              i_clk,
    input  logic              i_reset_n,
    bilinear_interp_if.slave  pix_bus
);
    import interp_pkg::*;

    logic [FRAC_W-1:0] fx_q;
    logic [FRAC_W-1:0] fy_q;
    logic [PIX_W-1:0]  b11_q;
    logic [PIX_W-1:0]  b12_q;
    logic [PIX_W-1:0]  b21_q;
    logic [PIX_W-1:0]  b22_q;
    logic [FRAC_W:0]   wx;
    logic [FRAC_W:0]   wy;
    logic [LAT-1:0]    vld_sr;
    logic [LAT-1:0]    fs_sr;
    logic              v3;
    logic              v4;
    logic              f3;
    idx_t              col_q;
    idx_t              row_q;
    logic [R_W-1:0]    r;
    logic [G_W-1:0]    g;
    logic [B_W-1:0]    b;

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            fx_q   <= '0;
            fy_q   <= '0;
            b11_q  <= '0;
            b12_q  <= '0;
            b21_q  <= '0;
            b22_q  <= '0;
            vld_sr <= '0;
            fs_sr  <= '0;
        end else begin
            fx_q   <= pix_bus.iv_fx;
            fy_q   <= pix_bus.iv_fy;
            b11_q  <= pix_bus.iv_b11;
            b12_q  <= pix_bus.iv_b12;
            b21_q  <= pix_bus.iv_b21;
            b22_q  <= pix_bus.iv_b22;
            vld_sr <= {vld_sr[LAT-2:0], pix_bus.i_hsyn};
            fs_sr  <= {fs_sr[LAT-2:0], pix_bus.i_fsyn};
        end
    end

    assign wx = (FRAC_W+1)'(WEIGHT_ONE) - {1'b0, fx_q};
    assign wy = (FRAC_W+1)'(WEIGHT_ONE) - {1'b0, fy_q};

    // v3/f3 describe the pixel entering the output register on the next edge.
    assign v3 = vld_sr[LAT-2];
    assign v4 = vld_sr[LAT-1];
    assign f3 = fs_sr[LAT-2];

    lerp_ch #(.CW(R_W), .FRAC_W(FRAC_W)) u_lerp_r (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .en(v3),
        .b11(b11_q[R_LSB +: R_W]), .b12(b12_q[R_LSB +: R_W]),
        .b21(b21_q[R_LSB +: R_W]), .b22(b22_q[R_LSB +: R_W]),
        .wx(wx), .wy(wy), .fx(fx_q), .fy(fy_q), .res(r)
    );

    lerp_ch #(.CW(G_W), .FRAC_W(FRAC_W)) u_lerp_g (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .en(v3),
        .b11(b11_q[G_LSB +: G_W]), .b12(b12_q[G_LSB +: G_W]),
        .b21(b21_q[G_LSB +: G_W]), .b22(b22_q[G_LSB +: G_W]),
        .wx(wx), .wy(wy), .fx(fx_q), .fy(fy_q), .res(g)
    );

    lerp_ch #(.CW(B_W), .FRAC_W(FRAC_W)) u_lerp_b (
        .i_clk(i_clk), .i_reset_n(i_reset_n), .en(v3),
        .b11(b11_q[B_LSB +: B_W]), .b12(b12_q[B_LSB +: B_W]),
        .b21(b21_q[B_LSB +: B_W]), .b22(b22_q[B_LSB +: B_W]),
        .wx(wx), .wy(wy), .fx(fx_q), .fy(fy_q), .res(b)
    );

    // Frame sync wins over a coincident end of line.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            col_q <= '0;
            row_q <= '0;
        end else if (f3) begin
            col_q <= '0;
            row_q <= '0;
        end else if (v4 && !v3) begin
            col_q <= '0;
            row_q <= sat_inc(row_q);
        end else if (v3 && v4) begin
            col_q <= sat_inc(col_q);
        end else if (v3) begin
            col_q <= '0;
        end
    end

    assign pix_bus.o_fsyn = fs_sr[LAT-1];
    assign pix_bus.o_hsyn = v4;
    assign pix_bus.ov_pix = PIX_W'({r, g, b});
    assign pix_bus.ov_col = col_q;
    assign pix_bus.ov_row = row_q;

endmodule
